frame_tick_monitor: RTL and testbench
=====================================

# frame_tick_monitor

Receives the slow divided frame clock (60 Hz by default) produced by the clock divider, resynchronizes it into the `clk_i` domain and emits one-cycle frame-tick pulses for the game logic. It measures each frame period in `clk_i` cycles and reports lock status, so game-state logic advances only on a verified, stable frame clock. It sits between the divider output and the game FSM/renderer enable inputs.

## Interface
- `CLK_FREQ_HZ`, 50000000: frequency of `clk_i` in Hz.
- `TICK_FREQ_HZ`, 60: nominal frequency of `tick_clk_i` in Hz.
- `TOL_CYCLES`, 1024: allowed deviation of a measured period from nominal, in `clk_i` cycles.
- `LOCK_COUNT`, 4: number of consecutive good periods required to lock.
- `FRAME_W`, 16: width of the frame counter.
- Derived: `PERIOD = 2*(CLK_FREQ_HZ/(2*TICK_FREQ_HZ))` (integer division, matching the divider output exactly); `TIMEOUT = PERIOD + TOL_CYCLES`; `CNT_W = $clog2(TIMEOUT+2)`.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `tick_clk_i` in 1: divided frame clock; treated as asynchronous.
- `tick_o` out 1: one-cycle pulse per synchronized rising edge of `tick_clk_i`.
- `locked_o` out 1: high while the frame clock is verified stable.
- `lost_o` out 1: one-cycle pulse when lock is lost.
- `period_o` out CNT_W: last measured period in `clk_i` cycles.
- `frame_cnt_o` out FRAME_W: count of `tick_o` pulses; wraps.

## Operation
- Synchronizer: two flops `s1`, `s2`, plus history flop `s3`. Internal `rise = s2 & ~s3`.
- Period counter `cnt_r`:
  - cleared to 0 on `rise`;
  - otherwise increments, saturating at `TIMEOUT`.
  - On `rise`, `period_o <= cnt_r + 1`.
- `good = (period >= PERIOD-TOL_CYCLES) && (period <= PERIOD+TOL_CYCLES)`, where `period = cnt_r + 1`. Underflow of `PERIOD-TOL_CYCLES` clamps to 0.
- `frame_cnt_o` increments on every `rise` in any state; wraps from all-ones to 0.
- FSM states IDLE, MEASURE, LOCKED, with `good_cnt` (0..LOCK_COUNT):
  - **IDLE**:
    - `rise` → MEASURE, `good_cnt = 0`. The first period is not evaluated.
    - Timeout is ignored.
  - **MEASURE**:
    - `rise` & `good`: `good_cnt++`; on reaching LOCK_COUNT → LOCKED.
    - `rise` & !`good`: `good_cnt = 0`, stay in MEASURE.
    - Timeout → IDLE.
  - **LOCKED**:
    - `rise` & `good`: stay.
    - `rise` & !`good` → MEASURE with `good_cnt = 0`, pulse `lost_o`.
    - Timeout → IDLE, pulse `lost_o`.
- Timeout is defined as `cnt_r == TIMEOUT && !rise`. `rise` has priority over timeout. A period of exactly `TIMEOUT+1` is evaluated as a bad period, not as a timeout.
- `period_o` is unchanged on timeout.
- `locked_o` is 1 exactly while the state is LOCKED.

## Timing
- Reset (asynchronous, immediate):
  - all outputs = 0;
  - `s1`/`s2`/`s3` = 0, `cnt_r` = 0, `good_cnt` = 0, state = IDLE.
- Reset mid-operation discards lock and all counts.
- `tick_o` latency: edge 1 of `clk_i` samples `tick_clk_i` high; `tick_o` is high for one cycle starting at edge 3.
- Update alignment:
  - `period_o`, `frame_cnt_o`, state and `locked_o` update on the same edge `tick_o` asserts.
  - `lost_o` on a bad period coincides with that `tick_o`.
  - `lost_o` on timeout occurs at edge `a+TIMEOUT+1`, where `a` is the edge of the last `rise`.
- Lock timing: `locked_o` rises together with the (LOCK_COUNT+1)-th `tick_o` after IDLE.
- Glitch-free `tick_clk_i` high/low phases of at least 2 `clk_i` cycles are required; narrower phases may be missed.

## Test plan
Bench parameters: `CLK_FREQ_HZ=1000`, `TICK_FREQ_HZ=50`, `TOL_CYCLES=2`, `LOCK_COUNT=4`, `FRAME_W=4`. This gives `PERIOD=20`, `TIMEOUT=22`.
- **Reset**: assert `rst_i` asynchronously mid-cycle → all outputs 0 immediately.
  - Release reset, hold `tick_clk_i` low for 100 cycles → `locked_o=0`, no `tick_o`/`lost_o`.
- **Lock acquisition**: drive `tick_clk_i` with 10 high / 10 low.
  - `tick_o` every 20 cycles, 2 edges after sampling.
  - `period_o=20` from the 2nd tick.
  - `locked_o` rises with the 5th `tick_o`.
  - `frame_cnt_o=5` at that point.
- **Tolerance**: after lock, apply periods 19, 21, 22 → lock held. Then apply period 23 → `lost_o` pulses with that `tick_o`, `locked_o=0`, `period_o=23`, state MEASURE. A further 4 periods of 20 → relock.
- **Timeout**: after lock, stop toggling (hold low).
  - `lost_o` pulses exactly 23 cycles after the last `rise` edge; `locked_o=0`; `period_o` stays 20.
  - Resume toggling → 5 ticks are needed to relock.
- **Wrap and reset mid-lock**:
  - 17 ticks → `frame_cnt_o` sequence reaches 15, then 0, then 1.
  - Assert `rst_i` while locked → `locked_o`, `frame_cnt_o`, `period_o` = 0 at once.

Source files
------------

// File: rtl/frame_tick_monitor.sv
// Resynchronizes the divided frame clock into clk_i, emits one-cycle frame ticks,
// measures each frame period and reports lock on a stable frame clock.
module frame_tick_monitor #(
   parameter int  CLK_FREQ_HZ  = 50000000,
   parameter int  TICK_FREQ_HZ = 60,
   parameter int  TOL_CYCLES   = 1024,
   parameter int  LOCK_COUNT   = 4,
   parameter int  FRAME_W      = 16,
   localparam int PERIOD       = 2 * (CLK_FREQ_HZ / (2 * TICK_FREQ_HZ)),
   localparam int TIMEOUT      = PERIOD + TOL_CYCLES,
   localparam int CNT_W        = $clog2(TIMEOUT + 2)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               tick_clk_i,
   output logic               tick_o,
   output logic               locked_o,
   output logic               lost_o,
   output logic [CNT_W-1:0]   period_o,
   output logic [FRAME_W-1:0] frame_cnt_o
);
   localparam int LO_LIMIT = (PERIOD > TOL_CYCLES) ? (PERIOD - TOL_CYCLES) : 0;
   localparam int GC_W     = $clog2(LOCK_COUNT + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] MEASURE = 2'd1;
   localparam logic [1:0] LOCKED  = 2'd2;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LO_C      = CNT_W'(LO_LIMIT);
   localparam logic [CNT_W-1:0] HI_C      = CNT_W'(PERIOD + TOL_CYCLES);
   localparam logic [GC_W-1:0]  LOCK_C    = GC_W'(LOCK_COUNT);

   logic               r_s1;
   logic               r_s2;
   logic               r_s3;
   logic [CNT_W-1:0]   r_cnt;
   logic [1:0]         r_state;
   logic [GC_W-1:0]    r_good_cnt;
   logic               r_tick;
   logic               r_lost;
   logic [CNT_W-1:0]   r_period;
   logic [FRAME_W-1:0] r_frame_cnt;

   logic               w_rise;
   logic [CNT_W-1:0]   w_period;
   logic               w_good;
   logic               w_timeout;
   logic [1:0]         w_state_next;
   logic [GC_W-1:0]    w_good_cnt_next;
   logic               w_lost_next;

   assign w_rise    = r_s2 & ~r_s3;
   // The counter is cleared on the rise edge itself, so the period is one more than its value.
   assign w_period  = r_cnt + CNT_W'(1);
   assign w_good    = (w_period >= LO_C) && (w_period <= HI_C);
   assign w_timeout = (r_cnt == TIMEOUT_C) && !w_rise;

   always_comb begin
      w_state_next    = r_state;
      w_good_cnt_next = r_good_cnt;
      w_lost_next     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_state_next    = MEASURE;
               w_good_cnt_next = '0;
            end
         end
         MEASURE: begin
            if (w_rise) begin
               if (w_good) begin
                  w_good_cnt_next = r_good_cnt + GC_W'(1);
                  if (r_good_cnt + GC_W'(1) == LOCK_C) begin
                     w_state_next = LOCKED;
                  end
               end else begin
                  w_good_cnt_next = '0;
               end
            end else if (w_timeout) begin
               w_state_next    = IDLE;
               w_good_cnt_next = '0;
            end
         end
         LOCKED: begin
            if (w_rise) begin
               if (!w_good) begin
                  w_state_next    = MEASURE;
                  w_good_cnt_next = '0;
                  w_lost_next     = 1'b1;
               end
            end else if (w_timeout) begin
               w_state_next    = IDLE;
               w_good_cnt_next = '0;
               w_lost_next     = 1'b1;
            end
         end
         default: begin
            w_state_next    = IDLE;
            w_good_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_s1        <= 1'b0;
         r_s2        <= 1'b0;
         r_s3        <= 1'b0;
         r_cnt       <= '0;
         r_state     <= IDLE;
         r_good_cnt  <= '0;
         r_tick      <= 1'b0;
         r_lost      <= 1'b0;
         r_period    <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_s1       <= tick_clk_i;
         r_s2       <= r_s1;
         r_s3       <= r_s2;
         r_tick     <= w_rise;
         r_lost     <= w_lost_next;
         r_state    <= w_state_next;
         r_good_cnt <= w_good_cnt_next;
         if (w_rise) begin
            r_cnt       <= '0;
            r_period    <= w_period;
            r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
         end else if (r_cnt != TIMEOUT_C) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign tick_o      = r_tick;
   assign lost_o      = r_lost;
   assign locked_o    = (r_state == LOCKED);
   assign period_o    = r_period;
   assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_frame_tick_monitor.sv
// Bench for frame_tick_monitor: hand-computed vectors for lock, tolerance, timeout and wrap,
// plus randomized frame periods checked every cycle against an edge-counting reference model.
`timescale 1ns/1ps
module tb_frame_tick_monitor;
   localparam int FW   = 4;
   localparam int CW   = 5;
   localparam int PER  = 20;
   localparam int TOL  = 2;
   localparam int TMO  = 22;
   localparam int LOCKN = 4;

   localparam int M_IDLE    = 0;
   localparam int M_MEASURE = 1;
   localparam int M_LOCKED  = 2;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          tick_clk_i = 1'b0;
   logic          tick_o;
   logic          locked_o;
   logic          lost_o;
   logic [CW-1:0] period_o;
   logic [FW-1:0] frame_cnt_o;

   frame_tick_monitor #(
      .CLK_FREQ_HZ (1000),
      .TICK_FREQ_HZ(50),
      .TOL_CYCLES  (TOL),
      .LOCK_COUNT  (LOCKN),
      .FRAME_W     (FW)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .tick_clk_i (tick_clk_i),
      .tick_o     (tick_o),
      .locked_o   (locked_o),
      .lost_o     (lost_o),
      .period_o   (period_o),
      .frame_cnt_o(frame_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // Reference model: counts clk_i edges since reset and works in terms of rise events.
   int m_n, m_last, m_mode, m_good, m_period, m_frame;
   bit m_tick, m_lost;
   bit m_samp[$];

   function automatic void model_reset();
      m_n = 0; m_last = 0; m_mode = M_IDLE; m_good = 0;
      m_period = 0; m_frame = 0; m_tick = 0; m_lost = 0;
      m_samp.delete();
      for (int i = 0; i < 4; i++) m_samp.push_back(1'b0);
   endfunction

   function automatic void model_step(input bit s);
      int elapsed, per, sz;
      bit rise, good;
      m_n++;
      m_samp.push_back(s);
      if (m_samp.size() > 8) void'(m_samp.pop_front());
      sz = m_samp.size();
      // An input rising edge first sampled at edge k appears as a tick at edge k+2.
      rise = m_samp[sz-3] && !m_samp[sz-4];
      m_tick = rise;
      m_lost = 0;
      elapsed = m_n - m_last;
      if (rise) begin
         per = (elapsed > TMO + 1) ? TMO + 1 : elapsed;
         good = (per >= PER - TOL) && (per <= PER + TOL);
         m_period = per;
         m_frame = (m_frame + 1) % (1 << FW);
         m_last = m_n;
         if (m_mode == M_IDLE) begin
            m_mode = M_MEASURE; m_good = 0;
         end else if (m_mode == M_MEASURE) begin
            if (good) begin
               m_good++;
               if (m_good == LOCKN) m_mode = M_LOCKED;
            end else m_good = 0;
         end else if (!good) begin
            m_mode = M_MEASURE; m_good = 0; m_lost = 1;
         end
      end else if (elapsed >= TMO + 1 && m_mode != M_IDLE) begin
         if (m_mode == M_LOCKED) m_lost = 1;
         m_mode = M_IDLE; m_good = 0;
      end
   endfunction

   int gn = 0;
   int tick_cnt = 0, tick_edge = 0, lost_cnt = 0, lost_edge = 0;
   int snap_period = 0, snap_locked = 0, snap_lost = 0, snap_frame = 0;

   initial begin
      forever begin
         @(posedge clk_i);
         gn++;
         if (!rst_i) begin
            model_step(tick_clk_i);
            #1;
            chk("m_tick", tick_o, m_tick);
            chk("m_lost", lost_o, m_lost);
            chk("m_locked", locked_o, m_mode == M_LOCKED);
            chk("m_period", period_o, m_period);
            chk("m_frame", frame_cnt_o, m_frame);
            if (tick_o) begin
               tick_cnt++; tick_edge = gn;
               snap_period = period_o; snap_locked = locked_o;
               snap_lost = lost_o; snap_frame = frame_cnt_o;
            end
            if (lost_o) begin
               lost_cnt++; lost_edge = gn;
            end
         end
      end
   end

   task automatic drive_period(input int hi, input int lo);
      for (int i = 0; i < hi + lo; i++) begin
         @(negedge clk_i);
         tick_clk_i = (i < hi);
      end
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #3;
      rst_i = 1'b1;
      tick_clk_i = 1'b0;
      model_reset();
      #1;
      chk("rst_tick", tick_o, 0);
      chk("rst_lost", lost_o, 0);
      chk("rst_locked", locked_o, 0);
      chk("rst_period", period_o, 0);
      chk("rst_frame", frame_cnt_o, 0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   typedef struct {
      int hi;
      int lo;
      int period;
      int locked;
      int lost;
      int frame;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int t0, l0, te, len, hi;
      // Each record drives one input period; its expectations describe the tick it produces,
      // whose measured period is the length of the previous record.
      tbl[0]  = '{10, 10, 23, 0, 0, 1};
      tbl[1]  = '{10, 10, 20, 0, 0, 2};
      tbl[2]  = '{10, 10, 20, 0, 0, 3};
      tbl[3]  = '{10, 10, 20, 0, 0, 4};
      tbl[4]  = '{10,  9, 20, 1, 0, 5};
      tbl[5]  = '{10, 11, 19, 1, 0, 6};
      tbl[6]  = '{10, 12, 21, 1, 0, 7};
      tbl[7]  = '{10, 13, 22, 1, 0, 8};
      tbl[8]  = '{10, 10, 23, 0, 1, 9};
      tbl[9]  = '{10, 10, 20, 0, 0, 10};
      tbl[10] = '{10, 10, 20, 0, 0, 11};
      tbl[11] = '{10, 10, 20, 0, 0, 12};
      tbl[12] = '{10, 10, 20, 1, 0, 13};

      model_reset();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;

      drive_period(0, 100);
      chk("idle_ticks", tick_cnt, 0);
      chk("idle_lost", lost_cnt, 0);
      chk("idle_locked", locked_o, 0);

      for (int i = 0; i < 13; i++) begin
         t0 = tick_cnt;
         drive_period(tbl[i].hi, tbl[i].lo);
         chk("vec_ticks", tick_cnt - t0, 1);
         chk("vec_period", snap_period, tbl[i].period);
         chk("vec_locked", snap_locked, tbl[i].locked);
         chk("vec_lost", snap_lost, tbl[i].lost);
         chk("vec_frame", snap_frame, tbl[i].frame);
         $display("vec %0d: hi=%0d lo=%0d period=%0d locked=%0d lost=%0d frame=%0d",
                  i, tbl[i].hi, tbl[i].lo, snap_period, snap_locked, snap_lost, snap_frame);
      end

      te = tick_edge;
      l0 = lost_cnt;
      drive_period(0, 40);
      chk("tmo_lost_cnt", lost_cnt - l0, 1);
      chk("tmo_delay", lost_edge - te, TMO + 1);
      chk("tmo_locked", locked_o, 0);
      chk("tmo_period", period_o, 20);
      $display("timeout: lost %0d edges after last rise", lost_edge - te);

      for (int k = 1; k <= 5; k++) begin
         drive_period(10, 10);
         chk("relock", snap_locked, (k == 5) ? 1 : 0);
         $display("relock tick %0d: locked=%0d", k, snap_locked);
      end

      do_reset();
      for (int k = 1; k <= 17; k++) begin
         drive_period(10, 10);
         chk("wrap_frame", snap_frame, k % 16);
         $display("wrap tick %0d: frame=%0d", k, snap_frame);
      end
      chk("wrap_locked", locked_o, 1);
      do_reset();
      $display("reset while locked applied");

      t0 = tick_cnt;
      for (int r = 0; r < 60; r++) begin
         len = $urandom_range(17, 25);
         if ($urandom_range(0, 7) == 0) len = 40;
         hi = $urandom_range(2, len - 2);
         drive_period(hi, len - hi);
      end
      drive_period(0, 30);
      chk("rand_ticks", tick_cnt - t0, 60);
      $display("random: 60 periods applied, %0d ticks seen", tick_cnt - t0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
